// File: rtl/branch_on_equal_pkg.sv
// Shared decision encodings and occupancy type for the branch_on_equal stage.
package branch_on_equal_pkg;
    localparam logic [1:0] DEC_EQ = 2'b10;
    localparam logic [1:0] DEC_NE = 2'b01;
    localparam logic [1:0] OCC_FULL = 2'd2;

    typedef logic [1:0] occ_t;
endpackage

// File: rtl/branch_on_equal_token_fifo2.sv
// Two-entry FIFO with a registered head entry; pops are ignored while empty.
module token_fifo2
    import branch_on_equal_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output occ_t             occupancy,
    output logic             valid
);
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    occ_t             occ_q, occ_d;
    logic             pop_en;

    assign pop_en = pop & (occ_q != 2'd0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case (occ_q)
            2'd0: if (push) begin
                head_d = data_in;
                occ_d  = 2'd1;
            end
            2'd1: begin
                if (push && pop_en) head_d = data_in;
                else if (push) begin
                    tail_d = data_in;
                    occ_d  = 2'd2;
                end else if (pop_en) occ_d = 2'd0;
            end
            default: if (pop_en) begin
                // Tail moves up; a simultaneous push refills the tail slot.
                head_d = tail_q;
                if (push) tail_d = data_in;
                else occ_d = 2'd1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign data_out  = head_q;
    assign occupancy = occ_q;
    assign valid     = (occ_q != 2'd0);
endmodule

// File: rtl/branch_on_equal.sv
// Steers each accepted token to the eq or ne branch FIFO by its one-hot decision.
// Optional per-branch accept counters are enabled by BRANCH_ON_EQUAL_COUNT_EN.
module branch_on_equal
    import branch_on_equal_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_equal,
    input  logic             in_notequal,
    output logic             eq_valid,
    input  logic             eq_ready,
    output logic [WIDTH-1:0] eq_data,
    output logic             ne_valid,
    input  logic             ne_ready,
    output logic [WIDTH-1:0] ne_data,
`ifdef BRANCH_ON_EQUAL_COUNT_EN
    output logic [15:0]      eq_count,
    output logic [15:0]      ne_count,
`endif
    output logic             err,
    input  logic             clr
);
    occ_t       eq_occ, ne_occ;
    logic [1:0] dec;
    logic       accept, push_eq, push_ne, bad;
    logic       err_q, err_d;

    // in_ready looks only at registered occupancy, never at in_valid.
    assign in_ready = (eq_occ < OCC_FULL) & (ne_occ < OCC_FULL);
    assign accept   = in_valid & in_ready;
    assign dec      = {in_equal, in_notequal};
    assign push_eq  = accept & (dec == DEC_EQ);
    assign push_ne  = accept & (dec == DEC_NE);
    assign bad      = accept & (dec != DEC_EQ) & (dec != DEC_NE);

    token_fifo2 #(.WIDTH(WIDTH)) u_eq_fifo (
        .clk(clk), .rst(rst), .push(push_eq), .pop(eq_ready), .data_in(in_data),
        .data_out(eq_data), .occupancy(eq_occ), .valid(eq_valid)
    );

    token_fifo2 #(.WIDTH(WIDTH)) u_ne_fifo (
        .clk(clk), .rst(rst), .push(push_ne), .pop(ne_ready), .data_in(in_data),
        .data_out(ne_data), .occupancy(ne_occ), .valid(ne_valid)
    );

    always_comb begin
        err_d = err_q;
        if (bad) err_d = 1'b1;
        else if (clr) err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else err_q <= err_d;
    end

    assign err = err_q;

`ifdef BRANCH_ON_EQUAL_COUNT_EN
    logic [15:0] eq_cnt_q, eq_cnt_d, ne_cnt_q, ne_cnt_d;

    always_comb begin
        eq_cnt_d = eq_cnt_q;
        ne_cnt_d = ne_cnt_q;
        if (clr) begin
            eq_cnt_d = '0;
            ne_cnt_d = '0;
        end else begin
            if (push_eq && eq_cnt_q != 16'hFFFF) eq_cnt_d = eq_cnt_q + 16'd1;
            if (push_ne && ne_cnt_q != 16'hFFFF) ne_cnt_d = ne_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_cnt_q <= '0;
            ne_cnt_q <= '0;
        end else begin
            eq_cnt_q <= eq_cnt_d;
            ne_cnt_q <= ne_cnt_d;
        end
    end

    assign eq_count = eq_cnt_q;
    assign ne_count = ne_cnt_q;
`endif
endmodule

// File: tb/tb_branch_on_equal.sv
// Directed bench for branch_on_equal; count checks built when BRANCH_ON_EQUAL_COUNT_EN is defined.
module tb_branch_on_equal;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_equal, in_notequal;
    logic [7:0] in_data, eq_data, ne_data;
    logic       eq_valid, eq_ready, ne_valid, ne_ready, err, clr;
`ifdef BRANCH_ON_EQUAL_COUNT_EN
    logic [15:0] eq_count, ne_count;
`endif
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    branch_on_equal #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_equal(in_equal), .in_notequal(in_notequal),
        .eq_valid(eq_valid), .eq_ready(eq_ready), .eq_data(eq_data),
        .ne_valid(ne_valid), .ne_ready(ne_ready), .ne_data(ne_data),
`ifdef BRANCH_ON_EQUAL_COUNT_EN
        .eq_count(eq_count), .ne_count(ne_count),
`endif
        .err(err), .clr(clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] dec);
        in_valid = v;
        in_data = d;
        {in_equal, in_notequal} = dec;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 2'b00);
        eq_ready = 1'b1; ne_ready = 1'b1; clr = 1'b0;
        #12;
        rst = 1'b0;
        step();
        total_cnt++;
        if ({eq_valid, ne_valid, err, in_ready} !== 4'b0001 || eq_data !== 8'h00 || ne_data !== 8'h00)
            $display("FAIL reset: v/v/err/rdy=%b eq=%h ne=%h want 0001 00 00",
                     {eq_valid, ne_valid, err, in_ready}, eq_data, ne_data);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        drive(1'b1, 8'h11, 2'b10);
        step();
        total_cnt++;
        if (eq_valid !== 1'b1 || eq_data !== 8'h11 || ne_valid !== 1'b0)
            $display("FAIL stream_eq1: eqv=%b eq=%h nev=%b want 1 11 0", eq_valid, eq_data, ne_valid);
        else pass_cnt++;
        drive(1'b1, 8'h22, 2'b01);
        step();
        total_cnt++;
        if (ne_valid !== 1'b1 || ne_data !== 8'h22 || eq_valid !== 1'b0)
            $display("FAIL stream_ne: nev=%b ne=%h eqv=%b want 1 22 0", ne_valid, ne_data, eq_valid);
        else pass_cnt++;
        drive(1'b1, 8'h33, 2'b10);
        step();
        total_cnt++;
        if (eq_valid !== 1'b1 || eq_data !== 8'h33 || ne_valid !== 1'b0 || err !== 1'b0)
            $display("FAIL stream_eq2: eqv=%b eq=%h nev=%b err=%b want 1 33 0 0",
                     eq_valid, eq_data, ne_valid, err);
        else pass_cnt++;
        drive(1'b0, 8'h00, 2'b00);
        step();
        total_cnt++;
        if (eq_valid !== 1'b0 || ne_valid !== 1'b0)
            $display("FAIL stream_drain: eqv=%b nev=%b want 0 0", eq_valid, ne_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        ne_ready = 1'b0;
        drive(1'b1, 8'hA1, 2'b01);
        step();
        total_cnt++;
        if (in_ready !== 1'b1 || ne_data !== 8'hA1)
            $display("FAIL bp_first: rdy=%b ne=%h want 1 a1", in_ready, ne_data);
        else pass_cnt++;
        drive(1'b1, 8'hA2, 2'b01);
        step();
        total_cnt++;
        if (in_ready !== 1'b0 || ne_data !== 8'hA1 || ne_valid !== 1'b1)
            $display("FAIL bp_full: rdy=%b ne=%h nev=%b want 0 a1 1", in_ready, ne_data, ne_valid);
        else pass_cnt++;
        drive(1'b1, 8'hA3, 2'b01);
        step();
        total_cnt++;
        if (in_ready !== 1'b0 || ne_data !== 8'hA1)
            $display("FAIL bp_hold: rdy=%b ne=%h want 0 a1", in_ready, ne_data);
        else pass_cnt++;
        ne_ready = 1'b1;
        step();
        total_cnt++;
        if (in_ready !== 1'b1 || ne_data !== 8'hA2 || ne_valid !== 1'b1)
            $display("FAIL bp_pop1: rdy=%b ne=%h nev=%b want 1 a2 1", in_ready, ne_data, ne_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (ne_data !== 8'hA3 || ne_valid !== 1'b1)
            $display("FAIL bp_pop2: ne=%h nev=%b want a3 1", ne_data, ne_valid);
        else pass_cnt++;
        drive(1'b0, 8'h00, 2'b00);
        step();
        total_cnt++;
        if (ne_valid !== 1'b0 || eq_valid !== 1'b0)
            $display("FAIL bp_empty: nev=%b eqv=%b want 0 0", ne_valid, eq_valid);
        else pass_cnt++;
    endtask

    task automatic test_malformed();
        drive(1'b1, 8'h55, 2'b11);
        step();
        total_cnt++;
        if (err !== 1'b1 || eq_valid !== 1'b0 || ne_valid !== 1'b0)
            $display("FAIL bad_11: err=%b eqv=%b nev=%b want 1 0 0", err, eq_valid, ne_valid);
        else pass_cnt++;
        drive(1'b1, 8'h66, 2'b00);
        step();
        total_cnt++;
        if (err !== 1'b1 || eq_valid !== 1'b0 || ne_valid !== 1'b0)
            $display("FAIL bad_00: err=%b eqv=%b nev=%b want 1 0 0", err, eq_valid, ne_valid);
        else pass_cnt++;
        drive(1'b0, 8'h00, 2'b00);
        clr = 1'b1;
        step();
        clr = 1'b0;
        total_cnt++;
        if (err !== 1'b0)
            $display("FAIL clr: err=%b want 0", err);
        else pass_cnt++;
    endtask

    task automatic test_set_clr();
        drive(1'b1, 8'h77, 2'b00);
        clr = 1'b1;
        step();
        drive(1'b0, 8'h00, 2'b00);
        total_cnt++;
        if (err !== 1'b1)
            $display("FAIL set_wins: err=%b want 1", err);
        else pass_cnt++;
        step();
        clr = 1'b0;
        total_cnt++;
        if (err !== 1'b0)
            $display("FAIL clr_after: err=%b want 0", err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h5A, 2'b11);
        step();
        eq_ready = 1'b0;
        drive(1'b1, 8'h88, 2'b10);
        step();
        drive(1'b1, 8'h99, 2'b10);
        step();
        drive(1'b0, 8'h00, 2'b00);
        total_cnt++;
        if (eq_valid !== 1'b1 || eq_data !== 8'h88 || in_ready !== 1'b0 || err !== 1'b1)
            $display("FAIL pre_rst: eqv=%b eq=%h rdy=%b err=%b want 1 88 0 1",
                     eq_valid, eq_data, in_ready, err);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (eq_valid !== 1'b0 || err !== 1'b0)
            $display("FAIL rst_async: eqv=%b err=%b want 0 0", eq_valid, err);
        else pass_cnt++;
        #1;
        rst = 1'b0;
        step();
        total_cnt++;
        if (in_ready !== 1'b1 || eq_valid !== 1'b0)
            $display("FAIL rst_release: rdy=%b eqv=%b want 1 0", in_ready, eq_valid);
        else pass_cnt++;
        eq_ready = 1'b1;
        step();
        step();
        total_cnt++;
        if (eq_valid !== 1'b0 || ne_valid !== 1'b0)
            $display("FAIL rst_flushed: eqv=%b nev=%b want 0 0", eq_valid, ne_valid);
        else pass_cnt++;
    endtask

`ifdef BRANCH_ON_EQUAL_COUNT_EN
    task automatic test_counts();
        logic [1:0] decs [5];
        decs = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), decs[i]);
            step();
        end
        drive(1'b0, 8'h00, 2'b00);
        total_cnt++;
        if (eq_count !== 16'd3 || ne_count !== 16'd2)
            $display("FAIL counts: eq=%0d ne=%0d want 3 2", eq_count, ne_count);
        else pass_cnt++;
        clr = 1'b1;
        drive(1'b1, 8'hC0, 2'b10);
        step();
        clr = 1'b0;
        drive(1'b0, 8'h00, 2'b00);
        total_cnt++;
        if (eq_count !== 16'd0 || ne_count !== 16'd0)
            $display("FAIL count_clr: eq=%0d ne=%0d want 0 0", eq_count, ne_count);
        else pass_cnt++;
        step();
        force dut.eq_cnt_q = 16'hFFFE;
        #1;
        release dut.eq_cnt_q;
        drive(1'b1, 8'hD1, 2'b10);
        step();
        drive(1'b1, 8'hD2, 2'b10);
        step();
        drive(1'b0, 8'h00, 2'b00);
        total_cnt++;
        if (eq_count !== 16'hFFFF)
            $display("FAIL count_sat: eq=%h want ffff", eq_count);
        else pass_cnt++;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_malformed();
        test_set_clr();
        test_reset_mid();
`ifdef BRANCH_ON_EQUAL_COUNT_EN
        test_counts();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/branch_on_equal.md
# branch_on_equal

Clocked routing stage that consumes the one-hot equal/not-equal decision from the comparison stage together with the data token it qualifies. It steers each token to one of two output channels. Each output channel has a 2-entry buffer, so a stalled branch does not block the other until its buffer fills. The block sits directly downstream of the equality comparator and feeds the two branch paths of the flow-control fabric.

## Interface
- WIDTH, 8, data token width in bits
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  upstream token present
- in_ready  out  1  stage can accept a token this cycle
- in_data  in  WIDTH  token payload
- in_equal  in  1  comparator "equal" decision
- in_notequal  in  1  comparator "not equal" decision
- eq_valid  out  1  equal-branch token present
- eq_ready  in  1  equal-branch consumer accepts
- eq_data  out  WIDTH  equal-branch payload
- ne_valid  out  1  not-equal-branch token present
- ne_ready  in  1  not-equal-branch consumer accepts
- ne_data  out  WIDTH  not-equal-branch payload
- err  out  1  sticky flag: malformed decision seen
- clr  in  1  synchronous clear of err (and counters, see Configuration)

## Operation
- Accept occurs when in_valid & in_ready at a clock edge.
- Decision decode at accept:
  - {in_equal,in_notequal}=10: push to the eq buffer.
  - 01: push to the ne buffer.
  - 00 or 11: token is consumed and discarded; err is set.
- Each branch has a 2-entry FIFO with occupancy 0..2.
  - x_valid = occupancy≠0.
  - x_data = head entry.
  - Pop on x_valid & x_ready.
- in_ready = (eq occupancy<2) & (ne occupancy<2). It depends on registered state only, never on in_valid or on decision inputs.
- Order is preserved within each branch. There is no ordering relation across branches.
- Push and pop on the same branch in the same cycle leaves occupancy unchanged. Allowed at occupancy 1 and 2; at occupancy 0 only the push takes effect.
- err set and clr in the same cycle: err=1 (set wins).

## Timing
- Reset (async assert, sync release): both occupancies 0; eq_valid=ne_valid=0; eq_data=ne_data=0; err=0; in_ready=1 from the first edge after release.
- Latency is 1 cycle: a token accepted at edge N is visible on x_valid/x_data after edge N.
- Throughput is 1 token/cycle while consumers keep their ready inputs high.
- Full: a branch at occupancy 2 forces in_ready=0 for both branches. A pop on that branch at edge N raises in_ready after edge N; there is no same-cycle bypass.
- x_valid and x_data hold stable until popped. Ready changes never alter them combinationally.
- rst asserted mid-operation discards all buffered tokens immediately. Upstream must re-present any token it had not had accepted.

## Configuration
- BRANCH_ON_EQUAL_COUNT_EN defined:
  - Adds outputs eq_count[15:0] and ne_count[15:0]. Each increments on accept into its branch and saturates at 16'hFFFF.
  - Reset value is 0; clr zeroes both.
  - clr on the same edge as an accept gives 0.
- Not defined: the count ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package: decision encoding constants (DEC_EQ=2'b10, DEC_NE=2'b01) and the 2-bit occupancy type.
- Sub-module token_fifo2 (WIDTH param; push, pop, data_in, data_out, occupancy, valid), instantiated once per branch.
- Top level holds the decode, in_ready, err and the optional counters.

## Test plan
- Reset then stream: tokens 0x11 (10), 0x22 (01), 0x33 (10), with both readies high → eq gets 0x11 then 0x33; ne gets 0x22; each appears 1 cycle after accept; err=0.
- Backpressure: ne_ready=0; send 0xA1, 0xA2, 0xA3 all (01) → in_ready drops after the second accept. Raise ne_ready → 0xA1, 0xA2 drain in order; 0xA3 is accepted the cycle after the first pop.
- Malformed decisions: send 0x55 with 11, then 0x66 with 00 → neither output asserts valid; err=1 one cycle after the first. Then clr=1 for one cycle → err=0.
- Same-cycle set/clear: a malformed token accepted on the same edge as clr=1 → err=1 afterwards.
- Reset mid-operation: eq holds 2 tokens; pulse rst between edges → eq_valid=0 and err=0 immediately; in_ready=1 after release; the held tokens are never emitted.
- With BRANCH_ON_EQUAL_COUNT_EN: 3 eq and 2 ne accepts → eq_count=3, ne_count=2; clr → both 0. Preload near saturation (force) and push twice → count holds at 0xFFFF.
